// File: rtl/loba_seq_mul_ctrl_if.sv
// Operand/product handshake bundle for the LOBA multiplier sequencer.
// A transfer happens on a rising clock edge where valid and ready are both high; valid,
// once raised, holds with its payload stable until that edge, and ready may depend on valid.
interface loba_seq_mul_ctrl_if #(
    parameter int N = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_a;
    logic [N-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_p;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/loba_seq_mul_ctrl.sv
// Multi-cycle leading-one-bit approximate multiplier: one leading-one detector is shared by
// both operands, each operand is cut to a P-bit window and one PxP product is shifted back.
module loba_seq_mul_ctrl #(
    parameter int N = 16,
    parameter int P = 4
) (
    input  logic                clk,
    input  logic                rst,
    loba_seq_mul_ctrl_if.slave  bus,
    output logic                busy,
    output logic [2:0]          dbg_state_o
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = KW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOB_A = 3'd1;
    localparam logic [2:0] S_LOB_B = 3'd2;
    localparam logic [2:0] S_MUL   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]     state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [KW-1:0]  ka_q, ka_d;
    logic [KW-1:0]  kb_q, kb_d;
    logic [2*N-1:0] p_q, p_d;

    logic           accept;
    logic           zero_in;
    logic [N-1:0]   lod_in;
    logic [KW-1:0]  lod_idx;
    logic [KW-1:0]  sa;
    logic [KW-1:0]  sb;
    logic [P-1:0]   ah;
    logic [P-1:0]   bh;
    logic [2*P-1:0] prod;
    logic [SW-1:0]  shamt;
    logic [2*N-1:0] prod_sh;

    // Amount to drop below the window; operands whose leading one sits inside the
    // window keep every bit, so small operands multiply exactly.
    function automatic logic [KW-1:0] win_shift(input logic [KW-1:0] k);
        if (k >= KW'(P - 1)) begin
            return k - KW'(P - 1);
        end
        return '0;
    endfunction

    // The single detector: its operand is chosen by which LOB state is active.
    assign lod_in = (state_q == S_LOB_B) ? b_q : a_q;

    always_comb begin
        lod_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (lod_in[i]) begin
                lod_idx = KW'(i);
            end
        end
    end

    assign sa      = win_shift(ka_q);
    assign sb      = win_shift(kb_q);
    assign ah      = P'(a_q >> sa);
    assign bh      = P'(b_q >> sb);
    assign prod    = {{P{1'b0}}, ah} * {{P{1'b0}}, bh};
    assign shamt   = {1'b0, sa} + {1'b0, sb};
    assign prod_sh = (2*N)'(prod) << shamt;

    // A pair is taken from IDLE, or from DONE in the same cycle the result drains.
    assign bus.in_ready = !rst && ((state_q == S_IDLE) ||
                                   ((state_q == S_DONE) && bus.out_ready));
    assign accept       = bus.in_ready && bus.in_valid;
    assign zero_in      = (bus.in_a == '0) || (bus.in_b == '0);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ka_d    = ka_q;
        kb_d    = kb_q;
        p_d     = p_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    a_d = bus.in_a;
                    b_d = bus.in_b;
                    if (zero_in) begin
                        p_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOB_A;
                    end
                end else if ((state_q == S_DONE) && bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_LOB_A: begin
                ka_d    = lod_idx;
                state_d = S_LOB_B;
            end
            S_LOB_B: begin
                kb_d    = lod_idx;
                state_d = S_MUL;
            end
            S_MUL: begin
                p_d     = prod_sh;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ka_q    <= '0;
            kb_q    <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ka_q    <= ka_d;
            kb_q    <= kb_d;
            p_q     <= p_d;
        end
    end

    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_p     = p_q;
    assign busy          = (state_q != S_IDLE);
    assign dbg_state_o   = state_q;
endmodule
